ea_sequencer: RTL and testbench
===============================

EA_SEQUENCER -- requirements
Module: ea_sequencer

Interface
REQ-001 CLK  in  1  single clock; all state changes on rising edge.
REQ-002 RESET_N  in  1  asynchronous, active-low reset.
REQ-003 START  in  1  request one effective-address (EA) formation; sampled only in IDLE.
REQ-004 IR  in  12  instruction word; captured on the accepted START edge.
REQ-005 PCLATCHED  in  12  address of the instruction; captured with IR.
REQ-006 MEMADDR  out  12  memory address for the current read or write.
REQ-007 MEMRD_REQ  out  1  memory read request; level, held until acknowledged.
REQ-008 MEMWR_REQ  out  1  memory write request; level, held until acknowledged.
REQ-009 MEMDOUT  out  12  write data.
REQ-010 MEMDIN  in  12  read data; valid on the edge where MEMACK=1.
REQ-011 MEMACK  in  1  memory acknowledge for the active request.
REQ-012 EA  out  12  effective address; holds its value until the next EA_VALID.
REQ-013 EA_VALID  out  1  one-cycle pulse; EA is valid while this is high.
REQ-014 BUSY  out  1  high in every state except IDLE.

Function
REQ-015 START in IDLE with IR[11:9] = 6 or 7 (IOT/OPR) shall be ignored: no state change and no pulse.
REQ-016 Pointer PTR = {PCLATCHED[11:7], IR[6:0]} when IR[7] = 1, else {5'b0, IR[6:0]}.
REQ-017 Auto-index condition AUTO = IR[8] & (PTR[11:3] == 9'o001), i.e. PTR in octal 0010..0017.
REQ-018 States: IDLE, RD, WR, DONE; all registered outputs come from registers.
REQ-019 IDLE + accepted START, IR[8] = 0 -> DONE with EA <= PTR, so EA_VALID is high the cycle after START (latency 1).
REQ-020 IDLE + accepted START, IR[8] = 1 -> RD with MEMADDR <= PTR and MEMRD_REQ <= 1.
REQ-021 RD: MEMRD_REQ and MEMADDR stay stable until an edge with MEMACK = 1.
REQ-022 RD, at that edge: when AUTO = 0 -> DONE with EA <= MEMDIN.
REQ-023 RD, at that edge: when AUTO = 1 -> WR with MEMDOUT <= (MEMDIN + 1) mod 4096 and MEMWR_REQ <= 1; MEMADDR unchanged; EA <= MEMDIN + 1.
REQ-024 WR: MEMWR_REQ, MEMADDR and MEMDOUT stay stable until an edge with MEMACK = 1, then DONE.
REQ-025 A request deasserts on the edge following its acknowledge; MEMRD_REQ and MEMWR_REQ are never high together.
REQ-026 DONE: EA_VALID = 1 for exactly one cycle, then IDLE. Back-to-back START is accepted the first cycle IDLE is re-entered.
REQ-027 START while BUSY = 1 shall be ignored and shall not queue.
REQ-028 MEMACK while no request is active shall be ignored.
REQ-029 Increment wraps: 7777 + 1 = 0000, with no carry out.
REQ-030 IR and PCLATCHED changes after the accepted START shall not affect the operation in progress.

Reset
REQ-031 RESET_N low -> immediately state IDLE; MEMRD_REQ, MEMWR_REQ, EA_VALID and BUSY = 0; MEMADDR, MEMDOUT and EA = 0000, independent of CLK.
REQ-032 Reset mid-operation abandons it: no EA_VALID pulse and no pending write; the first START after RESET_N rises is handled normally.

Verification (octal values)
REQ-033 IR=1045, PCLATCHED=2300, START -> next cycle EA=0045, EA_VALID pulse of 1 cycle, no memory request.
REQ-034 IR=5250, PCLATCHED=2300 -> EA=2250 at latency 1, no memory request.
REQ-035 IR=1440, memory returns 3456 after 3 wait cycles -> MEMRD_REQ held 4 cycles at MEMADDR=0040, EA=3456, MEMWR_REQ never high.
REQ-036 IR=3410, memory returns 7777 -> write of 0000 to 0010, then EA=0000.
REQ-036 (cont.) IR=1617 with PCLATCHED=0100 -> auto-index at 0017; IR=1617 with PCLATCHED=0200 -> plain indirect read of 0217, no write.
REQ-037 RESET_N low while in WR -> MEMWR_REQ drops asynchronously and EA_VALID never pulses.
REQ-037 (cont.) IR=6046 or 7200 with START -> BUSY stays 0; START pulses during BUSY are ignored.

Source files
------------

// File: rtl/ea_sequencer.sv
// Effective-address sequencer: forms direct, indirect and auto-indexed EAs
// from a captured instruction word, driving a level req/ack memory port.
module ea_sequencer (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [11:0] IR,
  input  logic [11:0] PCLATCHED,
  output logic [11:0] MEMADDR,
  output logic        MEMRD_REQ,
  output logic        MEMWR_REQ,
  output logic [11:0] MEMDOUT,
  input  logic [11:0] MEMDIN,
  input  logic        MEMACK,
  output logic [11:0] EA,
  output logic        EA_VALID,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] memaddr_q, memaddr_d;
  logic [11:0] memdout_q, memdout_d;
  logic [11:0] ea_q, ea_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        auto_q, auto_d;
  logic        ea_valid_q, ea_valid_d;
  logic        busy_q, busy_d;

  logic [11:0] ptr;
  logic        auto_idx;
  logic        accept;
  logic [11:0] din_inc;

  // Pointer, auto-index qualifier and accept decode from the live IR/PC
  always_comb begin
    ptr      = IR[7] ? {PCLATCHED[11:7], IR[6:0]} : {5'b0_0000, IR[6:0]};
    auto_idx = IR[8] & (ptr[11:3] == 9'o001);
    accept   = START & (IR[11:10] != 2'b11);
    din_inc  = MEMDIN + 12'd1;
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d    = state_q;
    memaddr_d  = memaddr_q;
    memdout_d  = memdout_q;
    ea_d       = ea_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    auto_d     = auto_q;
    ea_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (IR[8]) begin
            state_d   = S_RD;
            memaddr_d = ptr;
            rd_d      = 1'b1;
            auto_d    = auto_idx;
          end else begin
            state_d    = S_DONE;
            ea_d       = ptr;
            ea_valid_d = 1'b1;
          end
        end
      end
      S_RD: begin
        if (MEMACK) begin
          rd_d = 1'b0;
          if (auto_q) begin
            state_d   = S_WR;
            memdout_d = din_inc;
            wr_d      = 1'b1;
            ea_d      = din_inc;
          end else begin
            state_d    = S_DONE;
            ea_d       = MEMDIN;
            ea_valid_d = 1'b1;
          end
        end
      end
      S_WR: begin
        if (MEMACK) begin
          wr_d       = 1'b0;
          state_d    = S_DONE;
          ea_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      memaddr_q  <= '0;
      memdout_q  <= '0;
      ea_q       <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      auto_q     <= 1'b0;
      ea_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      memaddr_q  <= memaddr_d;
      memdout_q  <= memdout_d;
      ea_q       <= ea_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      auto_q     <= auto_d;
      ea_valid_q <= ea_valid_d;
      busy_q     <= busy_d;
    end
  end

  // Every output is a direct register copy
  always_comb begin
    MEMADDR   = memaddr_q;
    MEMDOUT   = memdout_q;
    MEMRD_REQ = rd_q;
    MEMWR_REQ = wr_q;
    EA        = ea_q;
    EA_VALID  = ea_valid_q;
    BUSY      = busy_q;
  end

endmodule

// File: tb/tb_ea_sequencer.sv
// Self-checking bench for ea_sequencer: directed octal cases, reset
// behaviour and randomized operations against a memory-array reference.
module tb_ea_sequencer;

  logic        CLK;
  logic        RESET_N;
  logic        START;
  logic [11:0] IR;
  logic [11:0] PCLATCHED;
  logic [11:0] MEMADDR;
  logic        MEMRD_REQ;
  logic        MEMWR_REQ;
  logic [11:0] MEMDOUT;
  logic [11:0] MEMDIN;
  logic        MEMACK;
  logic [11:0] EA;
  logic        EA_VALID;
  logic        BUSY;

  int unsigned total;
  int unsigned bad;
  logic [11:0] mem [4096];

  ea_sequencer dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .START     (START),
    .IR        (IR),
    .PCLATCHED (PCLATCHED),
    .MEMADDR   (MEMADDR),
    .MEMRD_REQ (MEMRD_REQ),
    .MEMWR_REQ (MEMWR_REQ),
    .MEMDOUT   (MEMDOUT),
    .MEMDIN    (MEMDIN),
    .MEMACK    (MEMACK),
    .EA        (EA),
    .EA_VALID  (EA_VALID),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
    end
  endtask

  // Issues one START at the current negedge (DUT idle) and acts as the
  // memory, checking the whole transaction against the array model.
  task automatic run_op(input logic [11:0] ir, input logic [11:0] pc,
                        input int unsigned rd_wait, input int unsigned wr_wait);
    logic        iot, indirect, autoi, done;
    logic [11:0] ptr, exp_ea, exp_wdata;
    int unsigned rd_cycles, wr_cycles, done_cyc;
    iot       = (ir[11:9] == 3'd6) || (ir[11:9] == 3'd7);
    ptr       = ir[7] ? ((pc & 12'o7600) | (ir & 12'o0177)) : (ir & 12'o0177);
    indirect  = ir[8];
    autoi     = indirect && (ptr >= 12'o0010) && (ptr <= 12'o0017);
    exp_wdata = mem[ptr] + 12'd1;
    exp_ea    = !indirect ? ptr : (autoi ? exp_wdata : mem[ptr]);
    rd_cycles = 0;
    wr_cycles = 0;
    done_cyc  = 0;
    done      = 1'b0;

    START     = 1'b1;
    IR        = ir;
    PCLATCHED = pc;
    MEMACK    = 1'($urandom % 2);
    MEMDIN    = 12'($urandom);
    @(negedge CLK);
    START     = 1'b0;
    IR        = 12'($urandom);
    PCLATCHED = 12'($urandom);
    MEMACK    = 1'b0;

    if (iot) begin
      check("iot_busy", {11'd0, BUSY}, 12'd0);
      check("iot_valid", {11'd0, EA_VALID}, 12'd0);
      check("iot_rd", {11'd0, MEMRD_REQ}, 12'd0);
      return;
    end

    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (cyc > 0) @(negedge CLK);
      MEMACK = 1'b0;
      MEMDIN = 12'($urandom);
      check("req_excl", {11'd0, MEMRD_REQ & MEMWR_REQ}, 12'd0);
      if (EA_VALID) begin
        done     = 1'b1;
        done_cyc = cyc;
        START    = 1'b0;
        MEMACK   = 1'($urandom % 2);
      end else begin
        if (MEMRD_REQ) begin
          rd_cycles++;
          check("rd_addr", MEMADDR, ptr);
          if (rd_cycles > rd_wait) begin
            MEMACK = 1'b1;
            MEMDIN = mem[MEMADDR];
          end
        end else if (MEMWR_REQ) begin
          wr_cycles++;
          check("wr_addr", MEMADDR, ptr);
          check("wr_data", MEMDOUT, exp_wdata);
          if (wr_cycles > wr_wait) begin
            MEMACK = 1'b1;
            mem[MEMADDR] = MEMDOUT;
          end
        end
        START = 1'($urandom % 2);
      end
    end

    check("timeout", {11'd0, done}, 12'd1);
    check("ea", EA, exp_ea);
    check("busy_done", {11'd0, BUSY}, 12'd1);
    check("rd_cycles", 12'(rd_cycles), indirect ? 12'(rd_wait + 1) : 12'd0);
    check("wr_cycles", 12'(wr_cycles), autoi ? 12'(wr_wait + 1) : 12'd0);
    check("latency", 12'(done_cyc),
          !indirect ? 12'd0 : 12'(rd_wait + 1 + (autoi ? wr_wait + 1 : 0)));
    @(negedge CLK);
    START  = 1'b0;
    MEMACK = 1'b0;
    check("valid_pulse", {11'd0, EA_VALID}, 12'd0);
    check("idle_busy", {11'd0, BUSY}, 12'd0);
    check("ea_hold", EA, exp_ea);
  endtask

  initial begin
    logic [11:0] rir;
    total     = 0;
    bad       = 0;
    RESET_N   = 1'b0;
    START     = 1'b0;
    IR        = '0;
    PCLATCHED = '0;
    MEMDIN    = '0;
    MEMACK    = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);

    #1;
    check("rst_busy", {11'd0, BUSY}, 12'd0);
    check("rst_valid", {11'd0, EA_VALID}, 12'd0);
    check("rst_rd", {11'd0, MEMRD_REQ}, 12'd0);
    check("rst_wr", {11'd0, MEMWR_REQ}, 12'd0);
    check("rst_ea", EA, 12'd0);
    check("rst_addr", MEMADDR, 12'd0);
    check("rst_dout", MEMDOUT, 12'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Directed octal cases, issued back to back
    run_op(12'o1045, 12'o2300, 0, 0);
    run_op(12'o5250, 12'o2300, 0, 0);
    mem[12'o0040] = 12'o3456;
    run_op(12'o1440, 12'o0000, 3, 0);
    mem[12'o0010] = 12'o7777;
    run_op(12'o3410, 12'o0000, 1, 2);
    check("wrap_mem", mem[12'o0010], 12'o0000);
    run_op(12'o1617, 12'o0100, 0, 0);
    run_op(12'o1617, 12'o0200, 2, 0);
    run_op(12'o6046, 12'o1234, 0, 0);
    run_op(12'o7200, 12'o1234, 0, 0);

    // Reset while the auto-index write is pending
    mem[12'o0010] = 12'o7777;
    START     = 1'b1;
    IR        = 12'o3410;
    PCLATCHED = 12'o0000;
    @(negedge CLK);
    START  = 1'b0;
    MEMACK = 1'b1;
    MEMDIN = 12'o7777;
    @(negedge CLK);
    MEMACK = 1'b0;
    check("rw_wr_req", {11'd0, MEMWR_REQ}, 12'd1);
    check("rw_wdata", MEMDOUT, 12'o0000);
    check("rw_waddr", MEMADDR, 12'o0010);
    #2 RESET_N = 1'b0;
    #1;
    check("arst_wr", {11'd0, MEMWR_REQ}, 12'd0);
    check("arst_busy", {11'd0, BUSY}, 12'd0);
    check("arst_addr", MEMADDR, 12'd0);
    check("arst_valid", {11'd0, EA_VALID}, 12'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      MEMACK = 1'($urandom % 2);
      @(negedge CLK);
      check("post_rst_valid", {11'd0, EA_VALID}, 12'd0);
      check("post_rst_busy", {11'd0, BUSY}, 12'd0);
    end
    MEMACK = 1'b0;
    run_op(12'o1045, 12'o2300, 0, 0);

    // Randomized operations, biased toward the auto-index window
    for (int n = 0; n < 60; n++) begin
      rir = 12'($urandom);
      if ($urandom % 2 == 1) rir = (rir & 12'o7407) | 12'o0010;
      if ($urandom % 3 != 0 && rir[11:10] == 2'b11) rir[11] = 1'b0;
      run_op(rir, 12'($urandom), $urandom % 4, $urandom % 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
